// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types for the registered immediate generator
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    // Immediate format selector as carried by decode; 3'b101/3'b110 are unassigned.
    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_CSR = 3'b111
    } imm_src_e;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/imm_ext.sv
// rtl/imm_ext.sv - combinational RV immediate extender
//
// Ports:
//   instr    in   32         full instruction word
//   imm_src  in   IMM_SRC_W  format selector (imm_src_e encoding)
//   imm      out  XLEN       extended immediate (0 for unassigned selectors)
module imm_ext
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]           instr,
    input  logic [IMM_SRC_W-1:0]  imm_src,
    output logic [XLEN-1:0]       imm
);

    logic        s;
    logic [31:0] imm32;
    logic        unused_opcode;

    assign s             = instr[31];
    assign unused_opcode = ^instr[6:0];

    // Every format is first formed as a 32-bit value whose bit 31 is the
    // correct extension bit (zero for CSR zimm and reserved codes), so the
    // widening to XLEN below is a uniform replication of bit 31.
    always_comb begin
        imm32 = 32'h0;
        case (imm_src_e'(imm_src))
            IMM_I:   imm32 = {{20{s}}, instr[31:20]};
            IMM_S:   imm32 = {{20{s}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'h000};
            IMM_CSR: imm32 = {27'h0, instr[19:15]};
            default: imm32 = 32'h0;
        endcase
    end

    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
//
// Optional feature macro: IMM_CHECK_EN (per-entry flag for reserved imm_src codes).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous drop of all buffered entries
//   in_valid/in_ready       upstream handshake (in_ready is a flop)
//   instr, imm_src, in_tag  instruction word, format selector, sideband tag
//   out_valid/out_ready     downstream handshake
//   imm, out_tag            extended immediate and its aligned tag
//   imm_err                 reserved-format flag travelling with the entry
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [IMM_SRC_W-1:0]  imm_src,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  imm_err
);

    logic [XLEN-1:0]  ext_imm;
    skid_state_e      state, state_nxt;
    logic             in_ready_q;
    logic             accept, drain;
    logic             load_head_in, load_head_skid, load_skid;

    // Head entry drives the outputs directly; the skid entry holds the
    // second item while downstream stalls.
    logic [XLEN-1:0]  head_imm, skid_imm;
    logic [TAG_W-1:0] head_tag, skid_tag;

    imm_ext #(.XLEN(XLEN)) u_ext (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (ext_imm)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;
    assign imm       = head_imm;
    assign out_tag   = head_tag;

    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_head_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so nothing can be accepted.
                    if (drain) begin
                        load_head_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_imm <= '0;
            head_tag <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else begin
            if (load_head_in) begin
                head_imm <= ext_imm;
                head_tag <= in_tag;
            end else if (load_head_skid) begin
                head_imm <= skid_imm;
                head_tag <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= ext_imm;
                skid_tag <= in_tag;
            end
        end
    end

`ifdef IMM_CHECK_EN
    logic ext_err;
    logic head_err, skid_err;

    assign ext_err = (imm_src == 3'b101) || (imm_src == 3'b110);
    assign imm_err = head_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_err <= 1'b0;
            skid_err <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_err <= ext_err;
            end else if (load_head_skid) begin
                head_err <= skid_err;
            end
            if (load_skid) begin
                skid_err <= ext_err;
            end
        end
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule
